// File: rtl/instr_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// ifq_pkg
//
// Shared types and constants for the instruction fetch queue.
//
//   ifq_entry_t  one buffered fetch result: the word address it came from and
//                the instruction word returned by instruction memory
//   ADDR_STEP    byte distance between consecutive sequential fetches
//   ALIGN_MASK   clears the byte-offset bits of a fetch address
//   next_word()  sequential successor of a word address (wraps at 2^32)
// -----------------------------------------------------------------------------
package ifq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    localparam int unsigned ADDR_STEP  = 4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFFFFFC;

    // 32-bit addition drops the carry, so 32'hFFFFFFFC wraps to 0.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'(ADDR_STEP);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// ifq_fifo
//
// Synchronous DEPTH-entry FIFO of ifq_entry_t used as the fetch buffer.
//
// Ports
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset (pointers and count only)
//   push_i    in   write wdata_i at the tail this cycle
//   wdata_i   in   entry to write
//   pop_i     in   retire the head this cycle (ignored while empty)
//   flush_i   in   discard every entry; dominates push and pop
//   rdata_o   out  head entry (meaningful only while !empty_o)
//   full_o    out  DEPTH entries held
//   empty_o   out  no entries held
//   count_o   out  number of entries held, 0..DEPTH
//
// A push while full is accepted only when a pop retires the head in the same
// cycle; a push while empty simply lands in the tail slot. In both cases the
// count is consistent and order is preserved. DEPTH must be a power of two so
// the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  ifq_entry_t    wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output ifq_entry_t    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    ifq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO frees the head slot in the same cycle it pops.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; an entry is only observed after it is written.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Consumer end of the program-counter path. Walks the fetch address
// sequentially from RESET_PC (or a redirect target), issues word reads to
// instruction memory, collects the in-order responses and buffers
// {pc, instruction} pairs for the decode stage.
//
// Parameters
//   DEPTH     queue entries and maximum outstanding reads (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk_i          in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   redirect_i     in   flush the queue and restart fetch at redirect_pc_i
//   redirect_pc_i  in   new fetch address, byte-offset bits ignored
//   imem_req_o     out  read request valid
//   imem_addr_o    out  read address, word aligned
//   imem_gnt_i     in   read request accepted this cycle
//   imem_rvalid_i  in   read data valid, responses in issue order
//   imem_rdata_i   in   read data
//   inst_valid_o   out  head instruction valid
//   inst_o         out  head instruction (0 while not valid)
//   inst_pc_o      out  address of head instruction (0 while not valid)
//   inst_ready_i   in   decode accepts the head
//
// Handshakes: a transfer happens in a cycle where both sides are high at the
// rising edge -- imem_req_o & imem_gnt_i issues a read, inst_valid_o &
// inst_ready_i pops the head. Once raised, imem_req_o and imem_addr_o hold
// until granted (only a redirect can withdraw a request, and a redirect
// already forces req low in its own cycle). imem_rvalid_i has no
// back-pressure.
//
// Configuration
//   IFQ_BYPASS_EN  when defined, a response that arrives while the queue is
//                  empty, nothing is being dropped and decode is ready goes
//                  straight to inst_o/inst_pc_o in the same cycle instead of
//                  being queued. When undefined, inst_* are driven only from
//                  the queue, so there is no combinational imem_* -> inst_*
//                  path.
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Fetch-side state.
    logic          run_q;
    logic [31:0]   addr_q,    addr_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q,   outst_d;
    logic [CW-1:0] drop_q,    drop_d;

    // Queue interface.
    ifq_entry_t    head;
    ifq_entry_t    push_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          fire;
    logic          accept;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_target;

    assign redirect_target = redirect_pc_i & ALIGN_MASK;

    // Every queued entry and every in-flight read (including ones that will
    // be dropped) holds a credit, so a granted read always has a slot.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};

    // run_q keeps req low through the first edge after reset release.
    assign imem_req_o  = run_q && !redirect_i && (credit_used < DEPTH_C);
    assign imem_addr_o = addr_q;
    assign fire        = imem_req_o && imem_gnt_i;

    // A response in a redirect cycle belongs to the abandoned stream.
    assign accept = imem_rvalid_i && (drop_q == '0) && !redirect_i;

`ifdef IFQ_BYPASS_EN
    assign bypass = fifo_empty && (drop_q == '0) && imem_rvalid_i &&
                    inst_ready_i && !redirect_i;
`else
    assign bypass = 1'b0;
`endif

    assign pop             = !fifo_empty && inst_ready_i;
    assign push            = accept && !bypass && (!fifo_full || pop);
    assign push_entry.pc   = resp_pc_q;
    assign push_entry.inst = imem_rdata_i;

    // Decode-facing outputs: queue head first, bypassed response otherwise.
    always_comb begin
        inst_valid_o = !fifo_empty;
        inst_o       = '0;
        inst_pc_o    = '0;
        if (!fifo_empty) begin
            inst_o    = head.inst;
            inst_pc_o = head.pc;
        end else if (bypass) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_rdata_i;
            inst_pc_o    = resp_pc_q;
        end
    end

    always_comb begin
        addr_d    = addr_q;
        resp_pc_d = resp_pc_q;
        // The credit rule keeps this within 0..DEPTH.
        outst_d   = outst_q + CW'(fire) - CW'(imem_rvalid_i);
        drop_d    = drop_q;
        if (redirect_i) begin
            addr_d    = redirect_target;
            resp_pc_d = redirect_target;
            // Everything still in flight after this cycle is stale. outst
            // already contains any earlier drop count, so this also
            // accumulates a redirect that lands while dropping.
            drop_d    = outst_d;
        end else begin
            if (fire) begin
                addr_d = next_word(addr_q);
            end
            if (accept) begin
                resp_pc_d = next_word(resp_pc_q);
            end
            if (imem_rvalid_i && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            run_q     <= 1'b0;
            addr_q    <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            run_q     <= 1'b1;
            addr_q    <= addr_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (reset),
        .push_i (push),
        .wdata_i(push_entry),
        .pop_i  (pop),
        .flush_i(redirect_i),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0). Instruction
// memory returns addr ^ 32'h5A5AA5A5 for every word. Define IFQ_BYPASS_EN for
// the bench and the design together to exercise the same-cycle bypass.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h00000000;
`ifdef IFQ_BYPASS_EN
    localparam int BP_EXTRA = 1;
`else
    localparam int BP_EXTRA = 0;
`endif

    logic        clk_i = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    // Clock / reset block: reset itself is driven by do_reset().
    always #5 clk_i = ~clk_i;

    instr_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i)
    );

    // Scoreboard: expected {pc, inst} in delivery order, and issued reads
    // {live, addr} awaiting a response.
    logic [63:0] exp_q[$];
    logic [32:0] pend_q[$];
    logic [31:0] exp_fetch;
    logic        auto_resp;
    logic        first_arm;
    logic [31:0] first_pc;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_pop  = 0;
    int          n_fire = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5AA5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic note_pop(input logic [31:0] pc);
        n_pop++;
        if (first_arm) begin
            first_pc  = pc;
            first_arm = 1'b0;
        end
    endtask

    // Drive a response for the oldest pending read, if any.
    task automatic resp();
        logic [32:0] e;
        imem_rvalid_i = (pend_q.size() > 0);
        imem_rdata_i  = '0;
        if (pend_q.size() > 0) begin
            e = pend_q[0];
            imem_rdata_i = mem_word(e[31:0]);
        end
    endtask

    // One clock cycle: called just after a falling edge with inputs driven.
    // Samples outputs, updates the model for the coming rising edge, then
    // waits for the next falling edge and drives the responder.
    task automatic cyc();
        logic        s_fire, s_rv, s_valid, s_ready, s_redir, live, bp;
        logic [31:0] s_addr, s_pc, s_inst, s_rpc;
        logic [32:0] ent;
        logic [63:0] hd;
        #1;
        s_fire  = imem_req_o & imem_gnt_i;
        s_addr  = imem_addr_o;
        s_rv    = imem_rvalid_i;
        s_valid = inst_valid_o;
        s_ready = inst_ready_i;
        s_redir = redirect_i;
        s_rpc   = redirect_pc_i;
        s_pc    = inst_pc_o;
        s_inst  = inst_o;
        live    = 1'b0;
        ent     = '0;
        if (s_rv && pend_q.size() > 0) begin
            ent  = pend_q.pop_front();
            live = ent[32] && !s_redir;
        end
        bp = 1'b0;
`ifdef IFQ_BYPASS_EN
        bp = live && (exp_q.size() == 0) && s_ready;
`endif
        check("inst_valid", {31'b0, s_valid}, {31'b0, (exp_q.size() != 0) || bp});
        if (bp) begin
            check("bypass_pc", s_pc, ent[31:0]);
            check("bypass_inst", s_inst, mem_word(ent[31:0]));
            note_pop(s_pc);
        end else if (live) begin
            exp_q.push_back({ent[31:0], mem_word(ent[31:0])});
        end
        if (!bp && s_valid && s_ready && exp_q.size() > 0) begin
            hd = exp_q.pop_front();
            check("head_pc", s_pc, hd[63:32]);
            check("head_inst", s_inst, hd[31:0]);
            note_pop(s_pc);
        end
        if (s_fire) begin
            check("fetch_addr", s_addr, exp_fetch);
            pend_q.push_back({1'b1, exp_fetch});
            exp_fetch = exp_fetch + 32'd4;
            n_fire++;
        end
        if (s_redir) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i][32] = 1'b0;
            exp_fetch = s_rpc & 32'hFFFFFFFC;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (auto_resp) resp();
        else imem_rvalid_i = 1'b0;
    endtask

    // Asynchronous reset in the low phase; memory shares it, so pending
    // reads vanish. Returns at the falling edge where reset is released.
    task automatic do_reset();
        #2;
        reset         = 1'b1;
        imem_rvalid_i = 1'b0;
        pend_q.delete();
        exp_q.delete();
        exp_fetch = RESET_PC;
        #1;
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", inst_pc_o, 32'd0);
        @(negedge clk_i);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        inst_ready_i  = 1'b0;
        auto_resp     = 1'b0;
        first_arm     = 1'b0;
        first_pc      = '0;
        exp_fetch     = RESET_PC;

        // 1. Streaming from reset: gnt=1, 1-cycle responses, ready=1.
        do_reset();
        imem_gnt_i   = 1'b1;
        inst_ready_i = 1'b1;
        auto_resp    = 1'b1;
        cyc();
        #1;
        check("t1_req_rises", {31'b0, imem_req_o}, 32'd1);
        first_arm = 1'b1;
        first_pc  = 32'hFFFFFFFF;
        repeat (2) cyc();
        n_pop = 0;
        repeat (8) cyc();
        check("t1_no_gaps", n_pop, 32'd8);
        check("t1_first_pc", first_pc, 32'h0);

        // 2. Decode stalled: credits run out after DEPTH grants.
        do_reset();
        inst_ready_i = 1'b0;
        imem_gnt_i   = 1'b1;
        auto_resp    = 1'b1;
        n_fire       = 0;
        repeat (10) cyc();
        check("t2_grants", n_fire, DEPTH);
        #1;
        check("t2_req_low", {31'b0, imem_req_o}, 32'd0);
        check("t2_addr_hold", imem_addr_o, 32'h10);
        inst_ready_i = 1'b1;
        cyc();
        inst_ready_i = 1'b0;
        #1;
        check("t2_req_again", {31'b0, imem_req_o}, 32'd1);
        check("t2_addr_again", imem_addr_o, 32'h10);

        // 3. Redirect to 0x103 with two reads in flight.
        do_reset();
        auto_resp    = 1'b0;
        inst_ready_i = 1'b1;
        imem_gnt_i   = 1'b0;
        cyc();
        imem_gnt_i = 1'b1;
        repeat (2) cyc();
        imem_gnt_i = 1'b0;
        cyc();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        cyc();
        redirect_i = 1'b0;
        #1;
        check("t3_addr", imem_addr_o, 32'h100);
        first_arm  = 1'b1;
        first_pc   = 32'hFFFFFFFF;
        n_pop      = 0;
        imem_gnt_i = 1'b1;
        auto_resp  = 1'b1;
        resp();
        repeat (8) cyc();
        check("t3_first_pc", first_pc, 32'h100);
        check("t3_pops", n_pop, 5 + BP_EXTRA);

        // 4. Redirect and rvalid together, queue holding three entries.
        do_reset();
        auto_resp    = 1'b0;
        inst_ready_i = 1'b0;
        imem_gnt_i   = 1'b0;
        cyc();
        imem_gnt_i = 1'b1;
        repeat (4) cyc();
        imem_gnt_i = 1'b0;
        repeat (3) begin
            resp();
            cyc();
        end
        resp();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        cyc();
        redirect_i = 1'b0;
        #1;
        check("t4_flushed", {31'b0, inst_valid_o}, 32'd0);
        imem_gnt_i = 1'b1;
        cyc();
        imem_gnt_i   = 1'b0;
        inst_ready_i = 1'b1;
        first_arm    = 1'b1;
        first_pc     = 32'hFFFFFFFF;
        resp();
        repeat (3) cyc();
        check("t4_first_pc", first_pc, 32'h200);

        // 5. Grant withheld for five cycles.
        do_reset();
        auto_resp    = 1'b1;
        inst_ready_i = 1'b1;
        imem_gnt_i   = 1'b0;
        cyc();
        repeat (5) begin
            #1;
            check("t5_req_held", {31'b0, imem_req_o}, 32'd1);
            check("t5_addr_held", imem_addr_o, RESET_PC);
            cyc();
        end
        imem_gnt_i = 1'b1;
        n_pop      = 0;
        first_arm  = 1'b1;
        first_pc   = 32'hFFFFFFFF;
        repeat (6) cyc();
        check("t5_pops", n_pop, 4 + BP_EXTRA);
        check("t5_first_pc", first_pc, RESET_PC);

        // 6. Reset in the middle of the stream, then fetch resumes.
        #1;
        check("t6_pre_valid", {31'b0, inst_valid_o}, 32'd1);
        do_reset();
        first_arm = 1'b1;
        first_pc  = 32'hFFFFFFFF;
        n_pop     = 0;
        cyc();
        repeat (6) cyc();
        check("t6_first_pc", first_pc, RESET_PC);
        check("t6_pops", n_pop, 4 + BP_EXTRA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
